sar_ctrl: RTL

//  Successive-approximation controller for the time-domain SAR ADC.

---
 rtl/sar_ctrl_pkg.sv | 21 ++
 rtl/sar_wait_timer.sv | 36 +++
 rtl/sar_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sar_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | sar_ctrl_pkg : shared state encoding and defaults for the SAR ctrl    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package sar_ctrl_pkg;

  localparam int SAR_N_BITS_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_TRIAL  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } sar_state_t;

endpackage

`default_nettype wire

// File: rtl/sar_wait_timer.sv
// +----------------------------------------------------------------------+
// | sar_wait_timer : loadable down-counter, flags the last allowed cycle  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sar_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= TW'(TIMEOUT);
    end else if (run && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  // High during the TIMEOUT-th running cycle after a load.
  assign expired = run && (r_count == TW'(1));

endmodule

`default_nettype wire

// File: rtl/sar_ctrl.sv
// +----------------------------------------------------------------------+
// | sar_ctrl : successive-approximation controller, MSB-first, one bit    |
// | per TRIAL/WAIT pair, with per-bit decision timeout. Rev 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module sar_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS_DEF,
  parameter int SAMPLE_CYCLES = 2,
  parameter int TIMEOUT       = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              cmp_ready,
  input  logic              cmp_out,
  output logic              sample,
  output logic              cmp_trig,
  output logic [N_BITS-1:0] dac_code,
  output logic [N_BITS-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              timeout
);

  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);

  sar_state_t        r_state;
  logic [N_BITS-1:0] r_result;
  logic [IW-1:0]     r_bit;
  logic [SW-1:0]     r_samp_cnt;

  logic              w_tmr_expired;
  logic              w_decide;
  logic              w_decision;
  logic [N_BITS-1:0] w_result_upd;
  logic [N_BITS-1:0] w_next_trial;

  // TRIAL always precedes WAIT, so loading there arms the timer for WAIT entry.
  sar_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (r_state == ST_TRIAL),
    .run     (r_state == ST_WAIT),
    .expired (w_tmr_expired)
  );

  // A real decision beats an expiring timer in the same cycle.
  assign w_decide   = (r_state == ST_WAIT) && (cmp_ready || w_tmr_expired);
  assign w_decision = cmp_ready ? cmp_out : 1'b0;

  always_comb begin
    w_result_upd        = r_result;
    w_result_upd[r_bit] = w_decision;
  end

  assign w_next_trial = w_result_upd | (N_BITS'(1) << (r_bit - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_result   <= '0;
      r_bit      <= '0;
      r_samp_cnt <= '0;
      sample     <= 1'b0;
      cmp_trig   <= 1'b0;
      dac_code   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cmp_trig   <= 1'b0;
      data_valid <= 1'b0;
      if (!en) begin
        r_state  <= ST_IDLE;
        sample   <= 1'b0;
        busy     <= 1'b0;
        dac_code <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state    <= ST_SAMPLE;
              sample     <= 1'b1;
              busy       <= 1'b1;
              r_result   <= '0;
              timeout    <= 1'b0;
              r_bit      <= '0;
              r_samp_cnt <= SW'(SAMPLE_CYCLES - 1);
            end
          end
          ST_SAMPLE: begin
            if (r_samp_cnt == '0) begin
              r_state  <= ST_TRIAL;
              sample   <= 1'b0;
              r_bit    <= IW'(N_BITS - 1);
              cmp_trig <= 1'b1;
              dac_code <= N_BITS'(1) << (N_BITS - 1);
            end else begin
              r_samp_cnt <= r_samp_cnt - 1'b1;
            end
          end
          ST_TRIAL: begin
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (w_decide) begin
              r_result <= w_result_upd;
              if (!cmp_ready) begin
                timeout <= 1'b1;
              end
              if (r_bit == '0) begin
                r_state    <= ST_DONE;
                data_out   <= w_result_upd;
                data_valid <= 1'b1;
              end else begin
                r_state  <= ST_TRIAL;
                r_bit    <= r_bit - 1'b1;
                cmp_trig <= 1'b1;
                dac_code <= w_next_trial;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
